dmem_arbiter: RTL and testbench

Single-port data-memory arbiter placed between the pipelined CPU's MEM-stage port and the data memory, sharing that memory with an external requester (UART debug loader / DMA). CPU has priority; the external port uses a valid/ready handshake and is guaranteed service by a starvation counter. When the external port wins a contended cycle, the arbiter stalls the CPU.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_starve_cnt.sv | 43 ++++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_EXT = 1'b1
  } gnt_e;

  // Width needed to hold the values 0..starve_max inclusive.
  function automatic int starve_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating wait counter for the external port; clear has priority over increment.
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX = DEF_STARVE_MAX,
  parameter int W   = starve_w(DEF_STARVE_MAX)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter sharing one data-memory port with an external requester.
// Optional DMEM_ARB_LOCK_EN adds ext_lock, letting ext hold the port across transfers.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              ext_lock,
`endif
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STARVE_W = starve_w(STARVE_MAX);

  gnt_e              gnt_s;
  logic              cpu_req_s;
  logic              ext_xfer_s;
  logic              at_max_s;
  logic              lock_held_s;
  logic              ext_rvalid_q;
  logic              ext_rvalid_d;
  logic [DATA_W-1:0] ext_rdata_q;
  logic [DATA_W-1:0] ext_rdata_d;

  assign cpu_req_s = cpu_rd | cpu_wr;

  // Per-cycle grant: ext only wins an idle CPU cycle, a starved wait, or a held lock.
  always_comb begin
    gnt_s = GNT_CPU;
    if (ext_valid && (!cpu_req_s || at_max_s || lock_held_s)) begin
      gnt_s = GNT_EXT;
    end else begin
      gnt_s = GNT_CPU;
    end
  end

  assign ext_ready  = (gnt_s == GNT_EXT);
  assign ext_xfer_s = ext_valid & ext_ready;
  assign cpu_stall  = cpu_req_s & ext_ready;
  assign cpu_rdata  = mem_rdata;

  // Memory port mux; an idle CPU still drives address/data so strobes alone gate access.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    case (gnt_s)
      GNT_EXT: begin
        mem_rd    = ~ext_we;
        mem_wr    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      GNT_CPU: begin
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      default: begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    endcase
  end

  dmem_arb_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (STARVE_W)
  ) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc_i    (ext_valid & ~ext_ready),
    .clr_i    (~ext_valid | ext_xfer_s),
    .at_max_o (at_max_s)
  );

  // Ext read response: capture memory data in the transfer cycle, pulse valid next cycle.
  always_comb begin
    ext_rvalid_d = ext_xfer_s & ~ext_we;
    ext_rdata_d  = ext_rdata_q;
    if (ext_rvalid_d) begin
      ext_rdata_d = mem_rdata;
    end else begin
      ext_rdata_d = ext_rdata_q;
    end
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_held_q;
  logic lock_held_d;

  // Lock state follows ext_lock of each completed ext transfer.
  always_comb begin
    lock_held_d = lock_held_q;
    if (ext_xfer_s) begin
      lock_held_d = ext_lock;
    end else begin
      lock_held_d = lock_held_q;
    end
  end

  // Lock register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_held_q <= 1'b0;
    end else begin
      lock_held_q <= lock_held_d;
    end
  end

  assign lock_held_s = lock_held_q;
`else
  assign lock_held_s = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected ext accepts and read
// responses; a negedge monitor pops and compares them. Lock tests need DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_valid, ext_ready, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_rvalid;
`ifdef DMEM_ARB_LOCK_EN
  logic        ext_lock;
`endif
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        acc_q[$];
  exp_t        rsp_q[$];
  exp_t        e_mon;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .ext_lock(ext_lock),
`endif
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word-addressed memory model, preloaded while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[8] <= 32'h1234_5678;
      mem[9] <= 32'hA5A5_0001;
    end else if (mem_wr) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    to_neg();
    to_next();
  endtask

  // Monitor: every ext accept and read response must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (ext_ready) begin
        if (acc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ext_accept: unexpected accept at cycle %0d", cyc);
        end else begin
          e_mon = acc_q.pop_front();
          chk("ext_accept_cycle", 32'(cyc), 32'(e_mon.cyc));
          chk("ext_accept_stall", {31'd0, cpu_stall}, e_mon.val);
        end
      end
      if (ext_rvalid) begin
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ext_rvalid: unexpected response at cycle %0d", cyc);
        end else begin
          e_mon = rsp_q.pop_front();
          chk("ext_rvalid_cycle", 32'(cyc), 32'(e_mon.cyc));
          chk("ext_rdata", ext_rdata, e_mon.val);
        end
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h20; ext_wdata = 32'h0;
`ifdef DMEM_ARB_LOCK_EN
    ext_lock = 1'b0;
`endif

    // Reset held three cycles with ext_valid asserted.
    for (int k = 0; k < 3; k++) begin
      to_next();
      to_neg();
      chk("reset_rvalid", {31'd0, ext_rvalid}, 32'd0);
      chk("reset_rdata", ext_rdata, 32'd0);
    end
    to_next();
    reset = 1'b0;
    acc_q.push_back('{cyc, 32'd0});
    rsp_q.push_back('{cyc + 1, 32'h1234_5678});
    step();
    ext_valid = 1'b0;
    step();

    // CPU store then load, no ext traffic.
    cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    to_neg();
    chk("cpu_st_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("cpu_st_mem_addr", mem_addr, 32'h10);
    chk("cpu_st_stall", {31'd0, cpu_stall}, 32'd0);
    to_next();
    cpu_wr = 1'b0;
    step();
    cpu_rd = 1'b1; cpu_addr = 32'h10;
    to_neg();
    chk("cpu_ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("cpu_ld_mem_rd", {31'd0, mem_rd}, 32'd1);
    to_next();
    cpu_rd = 1'b0;
    step();

    // Back-to-back uncontended ext reads.
    ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
    acc_q.push_back('{cyc, 32'd0});
    rsp_q.push_back('{cyc + 1, 32'h1234_5678});
    step();
    ext_addr = 32'h24;
    acc_q.push_back('{cyc, 32'd0});
    rsp_q.push_back('{cyc + 1, 32'hA5A5_0001});
    step();
    ext_valid = 1'b0;
    step();
    step();

    // Contention: CPU loads every cycle, ext forced in after four waits, twice.
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    ext_valid = 1'b1; ext_addr = 32'h20;
    base = cyc;
    acc_q.push_back('{base + 4, 32'd1});
    rsp_q.push_back('{base + 5, 32'h1234_5678});
    for (int k = 0; k < 5; k++) begin
      to_neg();
      chk("contend_stall", {31'd0, cpu_stall}, (k == 4) ? 32'd1 : 32'd0);
      to_next();
    end
    ext_addr = 32'h24;
    acc_q.push_back('{base + 9, 32'd1});
    rsp_q.push_back('{base + 10, 32'hA5A5_0001});
    for (int k = 0; k < 5; k++) begin
      to_neg();
      chk("contend2_stall", {31'd0, cpu_stall}, (k == 4) ? 32'd1 : 32'd0);
      to_next();
    end
    ext_valid = 1'b0;
    step();

    // Ext write drops valid at cycle 2 of contention; wait restarts.
    ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 32'h30; ext_wdata = 32'h0000_55AA;
    base = cyc;
    acc_q.push_back('{base + 7, 32'd1});
    for (int k = 0; k < 8; k++) begin
      ext_valid = (k != 2);
      step();
    end
    ext_valid = 1'b0; ext_we = 1'b0;
    cpu_addr = 32'h30;
    to_neg();
    chk("ext_wr_readback", cpu_rdata, 32'h0000_55AA);
    to_next();
    cpu_rd = 1'b0;
    step();

`ifdef DMEM_ARB_LOCK_EN
    // Locked ext burst holds the port against CPU stores until released.
    ext_valid = 1'b1; ext_we = 1'b1; ext_lock = 1'b1; ext_addr = 32'h50; ext_wdata = 32'h1;
    acc_q.push_back('{cyc, 32'd0});
    step();
    cpu_wr = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'hCCCC;
    ext_addr = 32'h54;
    acc_q.push_back('{cyc, 32'd1});
    step();
    ext_addr = 32'h58;
    acc_q.push_back('{cyc, 32'd1});
    step();
    ext_lock = 1'b0; ext_addr = 32'h5C;
    acc_q.push_back('{cyc, 32'd1});
    step();
    to_neg();
    chk("unlock_ready", {31'd0, ext_ready}, 32'd0);
    chk("unlock_stall", {31'd0, cpu_stall}, 32'd0);
    to_next();
    ext_valid = 1'b0; cpu_wr = 1'b0; ext_we = 1'b0;
    step();
`endif

    // Read accepted in a reset cycle must not produce a response.
    reset = 1'b1; ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
    step();
    reset = 1'b0; ext_valid = 1'b0;
    to_neg();
    chk("rst_mid_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("rst_mid_rdata", ext_rdata, 32'd0);
    to_next();
    step();

    chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
